// File: rtl/cc_miss_req_ctrl.sv
// Refill request sequencer: turns tag-compare misses into AXI AR bursts plus a miss address FIFO push,
// and keeps a count of refills in flight, which it decrements on each RLAST beat.
module cc_miss_req_ctrl #(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned ARID_VAL        = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        miss_req_valid_i,
    input  logic [31:0] miss_req_addr_i,
    output logic        miss_req_ready_o,
    output logic [3:0]  mem_arid_o,
    output logic [31:0] mem_araddr_o,
    output logic [3:0]  mem_arlen_o,
    output logic [2:0]  mem_arsize_o,
    output logic [1:0]  mem_arburst_o,
    output logic        mem_arvalid_o,
    input  logic        mem_arready_i,
    input  logic        mem_rvalid_i,
    input  logic        mem_rready_i,
    input  logic        mem_rlast_i,
    input  logic        miss_addr_fifo_full_i,
    output logic        miss_addr_fifo_wren_o,
    output logic [31:0] miss_addr_fifo_wdata_o,
    output logic [3:0]  outstanding_cnt_o,
    output logic        busy_o,
    output logic        underflow_err_o
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               arvalid_nxt;
    logic [ADDR_W-1:0]  araddr_nxt;
    logic               wren_nxt;
    logic [ADDR_W-1:0]  wdata_nxt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               err_nxt;
    logic               accept;
    logic               retire;

    // Burst shape is fixed: one 64-byte line as 8 x 8-byte beats, wrapping from the critical word.
    assign mem_arid_o    = CNT_W'(ARID_VAL);
    assign mem_arlen_o   = 4'd7;
    assign mem_arsize_o  = 3'b011;
    assign mem_arburst_o = 2'b10;

    // Ready uses the registered count, so a retirement and an accept can share a cycle.
    assign miss_req_ready_o = (state == IDLE)
                           && (outstanding_cnt_o < CNT_W'(MAX_OUTSTANDING))
                           && !miss_addr_fifo_full_i;
    assign accept = miss_req_valid_i && miss_req_ready_o;
    assign retire = mem_rvalid_i && mem_rready_i && mem_rlast_i;
    assign busy_o = (state != IDLE) || (outstanding_cnt_o != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state                  <= IDLE;
            mem_arvalid_o          <= 1'b0;
            mem_araddr_o           <= '0;
            miss_addr_fifo_wren_o  <= 1'b0;
            miss_addr_fifo_wdata_o <= '0;
            outstanding_cnt_o      <= '0;
            underflow_err_o        <= 1'b0;
        end else begin
            state                  <= state_nxt;
            mem_arvalid_o          <= arvalid_nxt;
            mem_araddr_o           <= araddr_nxt;
            miss_addr_fifo_wren_o  <= wren_nxt;
            miss_addr_fifo_wdata_o <= wdata_nxt;
            outstanding_cnt_o      <= cnt_nxt;
            underflow_err_o        <= err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        arvalid_nxt = mem_arvalid_o;
        araddr_nxt  = mem_araddr_o;
        wren_nxt    = 1'b0;
        wdata_nxt   = miss_addr_fifo_wdata_o;
        err_nxt     = underflow_err_o;

        case (state)
            IDLE: begin
                if (accept) begin
                    araddr_nxt  = {miss_req_addr_i[31:3], 3'b000};
                    wdata_nxt   = miss_req_addr_i;
                    wren_nxt    = 1'b1;
                    arvalid_nxt = 1'b1;
                    state_nxt   = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_arready_i) begin
                    arvalid_nxt = 1'b0;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // The slot is reserved at accept; an RLAST with nothing in flight is flagged, not counted.
        if (retire && (outstanding_cnt_o == '0)) begin
            err_nxt = 1'b1;
        end
        cnt_nxt = outstanding_cnt_o + CNT_W'(accept)
                - CNT_W'(retire && (outstanding_cnt_o != '0));
    end

endmodule

// File: tb/tb_cc_miss_req_ctrl.sv
// Self-checking bench for cc_miss_req_ctrl: directed scenarios plus a randomized run
// checked against a transaction-level model (pending AR flag, in-flight count, expected-address queue).
module tb_cc_miss_req_ctrl;

    localparam int unsigned MAXO = 4;

    logic        clk;
    logic        rst_n;
    logic        miss_req_valid_i;
    logic [31:0] miss_req_addr_i;
    logic        miss_req_ready_o;
    logic [3:0]  mem_arid_o;
    logic [31:0] mem_araddr_o;
    logic [3:0]  mem_arlen_o;
    logic [2:0]  mem_arsize_o;
    logic [1:0]  mem_arburst_o;
    logic        mem_arvalid_o;
    logic        mem_arready_i;
    logic        mem_rvalid_i;
    logic        mem_rready_i;
    logic        mem_rlast_i;
    logic        miss_addr_fifo_full_i;
    logic        miss_addr_fifo_wren_o;
    logic [31:0] miss_addr_fifo_wdata_o;
    logic [3:0]  outstanding_cnt_o;
    logic        busy_o;
    logic        underflow_err_o;

    int tests;
    int fails;

    cc_miss_req_ctrl #(.MAX_OUTSTANDING(MAXO), .ARID_VAL(0)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .miss_req_valid_i       (miss_req_valid_i),
        .miss_req_addr_i        (miss_req_addr_i),
        .miss_req_ready_o       (miss_req_ready_o),
        .mem_arid_o             (mem_arid_o),
        .mem_araddr_o           (mem_araddr_o),
        .mem_arlen_o            (mem_arlen_o),
        .mem_arsize_o           (mem_arsize_o),
        .mem_arburst_o          (mem_arburst_o),
        .mem_arvalid_o          (mem_arvalid_o),
        .mem_arready_i          (mem_arready_i),
        .mem_rvalid_i           (mem_rvalid_i),
        .mem_rready_i           (mem_rready_i),
        .mem_rlast_i            (mem_rlast_i),
        .miss_addr_fifo_full_i  (miss_addr_fifo_full_i),
        .miss_addr_fifo_wren_o  (miss_addr_fifo_wren_o),
        .miss_addr_fifo_wdata_o (miss_addr_fifo_wdata_o),
        .outstanding_cnt_o      (outstanding_cnt_o),
        .busy_o                 (busy_o),
        .underflow_err_o        (underflow_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; every task samples and drives 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic retire_beats(input int n);
        for (int i = 0; i < n; i++) begin
            mem_rvalid_i = 1'b1; mem_rready_i = 1'b1; mem_rlast_i = 1'b1;
            tick();
        end
        mem_rvalid_i = 1'b0; mem_rready_i = 1'b0; mem_rlast_i = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        tests++; if (mem_arvalid_o !== 1'b0) begin fails++; $display("FAIL reset_arvalid got %0b want 0", mem_arvalid_o); end
        tests++; if (mem_araddr_o !== 32'h0) begin fails++; $display("FAIL reset_araddr got %h want 0", mem_araddr_o); end
        tests++; if (miss_addr_fifo_wren_o !== 1'b0) begin fails++; $display("FAIL reset_wren got %0b want 0", miss_addr_fifo_wren_o); end
        tests++; if (miss_addr_fifo_wdata_o !== 32'h0) begin fails++; $display("FAIL reset_wdata got %h want 0", miss_addr_fifo_wdata_o); end
        tests++; if (outstanding_cnt_o !== 4'd0) begin fails++; $display("FAIL reset_cnt got %0d want 0", outstanding_cnt_o); end
        tests++; if (underflow_err_o !== 1'b0) begin fails++; $display("FAIL reset_err got %0b want 0", underflow_err_o); end
        tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy got %0b want 0", busy_o); end
        tests++; if (miss_req_ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready got %0b want 1", miss_req_ready_o); end
        tests++; if ({mem_arid_o, mem_arlen_o, mem_arsize_o, mem_arburst_o} !== {4'd0, 4'd7, 3'b011, 2'b10}) begin
            fails++; $display("FAIL reset_const got id=%0d len=%0d size=%0d burst=%0d want 0/7/3/2",
                              mem_arid_o, mem_arlen_o, mem_arsize_o, mem_arburst_o);
        end
    endtask

    task automatic test_single_miss();
        mem_arready_i = 1'b1;
        miss_req_valid_i = 1'b1;
        miss_req_addr_i = 32'h0001_2358;
        #1;
        tests++; if (miss_req_ready_o !== 1'b1) begin fails++; $display("FAIL single_ready got %0b want 1", miss_req_ready_o); end
        tick();
        miss_req_valid_i = 1'b0;
        miss_req_addr_i = 32'hFFFF_FFFF;
        tests++; if (mem_arvalid_o !== 1'b1) begin fails++; $display("FAIL single_arvalid got %0b want 1", mem_arvalid_o); end
        tests++; if (mem_araddr_o !== 32'h0001_2358) begin fails++; $display("FAIL single_araddr got %h want 00012358", mem_araddr_o); end
        tests++; if (miss_addr_fifo_wren_o !== 1'b1) begin fails++; $display("FAIL single_wren got %0b want 1", miss_addr_fifo_wren_o); end
        tests++; if (miss_addr_fifo_wdata_o !== 32'h0001_2358) begin fails++; $display("FAIL single_wdata got %h want 00012358", miss_addr_fifo_wdata_o); end
        tests++; if (mem_arlen_o !== 4'd7 || mem_arburst_o !== 2'b10) begin fails++; $display("FAIL single_burst got len=%0d burst=%0d want 7/2", mem_arlen_o, mem_arburst_o); end
        tick();
        tests++; if (mem_arvalid_o !== 1'b0) begin fails++; $display("FAIL single_arvalid_drop got %0b want 0", mem_arvalid_o); end
        tests++; if (outstanding_cnt_o !== 4'd1) begin fails++; $display("FAIL single_cnt got %0d want 1", outstanding_cnt_o); end
        tests++; if (miss_addr_fifo_wren_o !== 1'b0) begin fails++; $display("FAIL single_wren_pulse got %0b want 0", miss_addr_fifo_wren_o); end
        for (int i = 0; i < 8; i++) begin
            mem_rvalid_i = 1'b1; mem_rready_i = 1'b1; mem_rlast_i = (i == 7);
            tick();
            tests++;
            if (outstanding_cnt_o !== ((i == 7) ? 4'd0 : 4'd1)) begin
                fails++; $display("FAIL single_beat%0d_cnt got %0d want %0d", i, outstanding_cnt_o, (i == 7) ? 0 : 1);
            end
        end
        mem_rvalid_i = 1'b0; mem_rready_i = 1'b0; mem_rlast_i = 1'b0;
        tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL single_busy got %0b want 0", busy_o); end
    endtask

    task automatic test_backpressure();
        int pushes;
        pushes = 0;
        mem_arready_i = 1'b0;
        miss_req_valid_i = 1'b1;
        miss_req_addr_i = 32'hDEAD_BEEF;
        tick();
        for (int c = 1; c <= 5; c++) begin
            miss_req_addr_i = $urandom;
            #1;
            if (miss_addr_fifo_wren_o === 1'b1) pushes++;
            tests++; if (mem_arvalid_o !== 1'b1) begin fails++; $display("FAIL bp_arvalid c%0d got %0b want 1", c, mem_arvalid_o); end
            tests++; if (mem_araddr_o !== 32'hDEAD_BEE8) begin fails++; $display("FAIL bp_araddr c%0d got %h want deadbee8", c, mem_araddr_o); end
            tests++; if (miss_req_ready_o !== 1'b0) begin fails++; $display("FAIL bp_ready c%0d got %0b want 0", c, miss_req_ready_o); end
            tick();
        end
        mem_arready_i = 1'b1;
        miss_req_valid_i = 1'b0;
        #1;
        if (miss_addr_fifo_wren_o === 1'b1) pushes++;
        tick();
        tests++; if (pushes != 1) begin fails++; $display("FAIL bp_pushes got %0d want 1", pushes); end
        tests++; if (mem_arvalid_o !== 1'b0) begin fails++; $display("FAIL bp_arvalid_end got %0b want 0", mem_arvalid_o); end
        tests++; if (miss_req_ready_o !== 1'b1) begin fails++; $display("FAIL bp_idle_ready got %0b want 1", miss_req_ready_o); end
        retire_beats(1);
    endtask

    task automatic test_outstanding_limit();
        mem_arready_i = 1'b1;
        for (int i = 0; i < int'(MAXO); i++) begin
            miss_req_valid_i = 1'b1;
            miss_req_addr_i = 32'h1000_0000 + 32'(i * 64);
            #1;
            tests++; if (miss_req_ready_o !== 1'b1) begin fails++; $display("FAIL lim_ready%0d got %0b want 1", i, miss_req_ready_o); end
            tick();
            miss_req_valid_i = 1'b0;
            tick();
        end
        tests++; if (outstanding_cnt_o !== 4'(MAXO)) begin fails++; $display("FAIL lim_cnt got %0d want %0d", outstanding_cnt_o, MAXO); end
        miss_req_valid_i = 1'b1;
        miss_req_addr_i = 32'h2000_0040;
        for (int c = 0; c < 3; c++) begin
            #1;
            tests++; if (miss_req_ready_o !== 1'b0) begin fails++; $display("FAIL lim_blocked c%0d got %0b want 0", c, miss_req_ready_o); end
            tick();
        end
        mem_rvalid_i = 1'b1; mem_rready_i = 1'b1; mem_rlast_i = 1'b1;
        tick();
        mem_rvalid_i = 1'b0; mem_rready_i = 1'b0; mem_rlast_i = 1'b0;
        tests++; if (outstanding_cnt_o !== 4'(MAXO - 1)) begin fails++; $display("FAIL lim_retire_cnt got %0d want %0d", outstanding_cnt_o, MAXO - 1); end
        tests++; if (miss_req_ready_o !== 1'b1) begin fails++; $display("FAIL lim_reopen got %0b want 1", miss_req_ready_o); end
        tick();
        miss_req_valid_i = 1'b0;
        tests++; if (mem_araddr_o !== 32'h2000_0040 || mem_arvalid_o !== 1'b1) begin
            fails++; $display("FAIL lim_fifth_ar got valid=%0b addr=%h want 1/20000040", mem_arvalid_o, mem_araddr_o);
        end
        tick();
        tests++; if (outstanding_cnt_o !== 4'(MAXO)) begin fails++; $display("FAIL lim_cnt_final got %0d want %0d", outstanding_cnt_o, MAXO); end
        retire_beats(int'(MAXO));
    endtask

    task automatic test_simultaneous();
        mem_arready_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            miss_req_valid_i = 1'b1; miss_req_addr_i = $urandom;
            tick();
            miss_req_valid_i = 1'b0;
            tick();
        end
        tests++; if (outstanding_cnt_o !== 4'd2) begin fails++; $display("FAIL sim_pre_cnt got %0d want 2", outstanding_cnt_o); end
        miss_req_valid_i = 1'b1; miss_req_addr_i = $urandom;
        mem_rvalid_i = 1'b1; mem_rready_i = 1'b1; mem_rlast_i = 1'b1;
        #1;
        tests++; if (miss_req_ready_o !== 1'b1) begin fails++; $display("FAIL sim_ready got %0b want 1", miss_req_ready_o); end
        tick();
        miss_req_valid_i = 1'b0;
        mem_rlast_i = 1'b0;
        tests++; if (outstanding_cnt_o !== 4'd2) begin fails++; $display("FAIL sim_cnt got %0d want 2", outstanding_cnt_o); end
        for (int c = 0; c < 5; c++) begin
            tick();
            tests++; if (outstanding_cnt_o !== 4'd2) begin fails++; $display("FAIL sim_nonlast c%0d got %0d want 2", c, outstanding_cnt_o); end
        end
        mem_rvalid_i = 1'b0; mem_rready_i = 1'b0;
        retire_beats(2);
    endtask

    task automatic test_fifo_full();
        mem_arready_i = 1'b1;
        miss_addr_fifo_full_i = 1'b1;
        miss_req_valid_i = 1'b1;
        miss_req_addr_i = 32'h0BAD_F00D;
        for (int c = 0; c < 3; c++) begin
            #1;
            tests++; if (miss_req_ready_o !== 1'b0) begin fails++; $display("FAIL full_ready c%0d got %0b want 0", c, miss_req_ready_o); end
            tick();
            tests++; if (mem_arvalid_o !== 1'b0 || miss_addr_fifo_wren_o !== 1'b0) begin
                fails++; $display("FAIL full_noissue c%0d got arvalid=%0b wren=%0b want 0/0", c, mem_arvalid_o, miss_addr_fifo_wren_o);
            end
        end
        miss_addr_fifo_full_i = 1'b0;
        #1;
        tests++; if (miss_req_ready_o !== 1'b1) begin fails++; $display("FAIL full_release got %0b want 1", miss_req_ready_o); end
        tick();
        miss_req_valid_i = 1'b0;
        tests++; if (mem_arvalid_o !== 1'b1 || miss_addr_fifo_wren_o !== 1'b1 || miss_addr_fifo_wdata_o !== 32'h0BAD_F00D) begin
            fails++; $display("FAIL full_accept got arvalid=%0b wren=%0b wdata=%h want 1/1/0badf00d",
                              mem_arvalid_o, miss_addr_fifo_wren_o, miss_addr_fifo_wdata_o);
        end
        tick();
        retire_beats(1);
    endtask

    task automatic test_underflow_reset();
        tests++; if (outstanding_cnt_o !== 4'd0) begin fails++; $display("FAIL uf_pre_cnt got %0d want 0", outstanding_cnt_o); end
        retire_beats(1);
        tests++; if (underflow_err_o !== 1'b1) begin fails++; $display("FAIL uf_err got %0b want 1", underflow_err_o); end
        tests++; if (outstanding_cnt_o !== 4'd0) begin fails++; $display("FAIL uf_cnt got %0d want 0", outstanding_cnt_o); end
        tick();
        tick();
        tests++; if (underflow_err_o !== 1'b1) begin fails++; $display("FAIL uf_sticky got %0b want 1", underflow_err_o); end
        mem_arready_i = 1'b0;
        miss_req_valid_i = 1'b1; miss_req_addr_i = 32'h0000_7777;
        tick();
        miss_req_valid_i = 1'b0;
        tests++; if (mem_arvalid_o !== 1'b1 || outstanding_cnt_o !== 4'd1) begin
            fails++; $display("FAIL uf_issue got arvalid=%0b cnt=%0d want 1/1", mem_arvalid_o, outstanding_cnt_o);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tests++; if (mem_arvalid_o !== 1'b0) begin fails++; $display("FAIL rst_arvalid got %0b want 0", mem_arvalid_o); end
        tests++; if (outstanding_cnt_o !== 4'd0) begin fails++; $display("FAIL rst_cnt got %0d want 0", outstanding_cnt_o); end
        tests++; if (underflow_err_o !== 1'b0) begin fails++; $display("FAIL rst_err got %0b want 0", underflow_err_o); end
        tests++; if (busy_o !== 1'b0 || miss_req_ready_o !== 1'b1) begin
            fails++; $display("FAIL rst_idle got busy=%0b ready=%0b want 0/1", busy_o, miss_req_ready_o);
        end
        mem_arready_i = 1'b1;
    endtask

    // Random traffic against a transaction-level model.
    task automatic test_random();
        bit          m_pend;
        int          m_cnt;
        bit          m_wren;
        logic [31:0] m_wdata;
        logic [31:0] ar_q[$];
        bit          exp_ready;
        bit          acc;
        bit          ret;
        bit          hs;
        apply_reset();
        m_pend = 0; m_cnt = 0; m_wren = 0; m_wdata = '0;
        for (int c = 0; c < 2000; c++) begin
            tests++; if (mem_arvalid_o !== m_pend) begin fails++; $display("FAIL rnd_arvalid c%0d got %0b want %0b", c, mem_arvalid_o, m_pend); end
            if (m_pend && ar_q.size() > 0) begin
                tests++; if (mem_araddr_o !== ar_q[0]) begin fails++; $display("FAIL rnd_araddr c%0d got %h want %h", c, mem_araddr_o, ar_q[0]); end
            end
            tests++; if (miss_addr_fifo_wren_o !== m_wren) begin fails++; $display("FAIL rnd_wren c%0d got %0b want %0b", c, miss_addr_fifo_wren_o, m_wren); end
            if (m_wren) begin
                tests++; if (miss_addr_fifo_wdata_o !== m_wdata) begin fails++; $display("FAIL rnd_wdata c%0d got %h want %h", c, miss_addr_fifo_wdata_o, m_wdata); end
            end
            tests++; if (int'(outstanding_cnt_o) != m_cnt) begin fails++; $display("FAIL rnd_cnt c%0d got %0d want %0d", c, outstanding_cnt_o, m_cnt); end
            tests++; if (busy_o !== (m_pend || m_cnt != 0)) begin fails++; $display("FAIL rnd_busy c%0d got %0b", c, busy_o); end
            tests++; if (underflow_err_o !== 1'b0) begin fails++; $display("FAIL rnd_err c%0d got %0b want 0", c, underflow_err_o); end

            miss_req_valid_i      = 1'($urandom % 2);
            miss_req_addr_i       = $urandom;
            mem_arready_i         = ($urandom % 3) != 0;
            miss_addr_fifo_full_i = ($urandom % 4) == 0;
            mem_rvalid_i          = 1'($urandom % 2);
            mem_rready_i          = 1'($urandom % 2);
            mem_rlast_i           = (m_cnt > 0) ? 1'($urandom % 2) : 1'b0;
            #1;
            exp_ready = !m_pend && (m_cnt < int'(MAXO)) && !miss_addr_fifo_full_i;
            tests++; if (miss_req_ready_o !== exp_ready) begin fails++; $display("FAIL rnd_ready c%0d got %0b want %0b", c, miss_req_ready_o, exp_ready); end

            acc = miss_req_valid_i && exp_ready;
            ret = mem_rvalid_i && mem_rready_i && mem_rlast_i;
            hs  = m_pend && mem_arready_i;
            m_wren = acc;
            if (acc) m_wdata = miss_req_addr_i;
            if (hs && ar_q.size() > 0) void'(ar_q.pop_front());
            if (acc) ar_q.push_back(miss_req_addr_i & 32'hFFFF_FFF8);
            if (acc) m_pend = 1;
            else if (hs) m_pend = 0;
            m_cnt = m_cnt + int'(acc) - int'(ret);
            tick();
        end
        miss_req_valid_i = 1'b0;
        miss_addr_fifo_full_i = 1'b0;
        mem_rvalid_i = 1'b0; mem_rready_i = 1'b0; mem_rlast_i = 1'b0;
        mem_arready_i = 1'b1;
        apply_reset();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        miss_req_valid_i = 1'b0;
        miss_req_addr_i = '0;
        mem_arready_i = 1'b1;
        mem_rvalid_i = 1'b0;
        mem_rready_i = 1'b0;
        mem_rlast_i = 1'b0;
        miss_addr_fifo_full_i = 1'b0;
        #2;
        test_reset();
        test_single_miss();
        test_backpressure();
        test_outstanding_limit();
        test_simultaneous();
        test_fifo_full();
        test_random();
        test_underflow_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
